stream_unit_driver: RTL and testbench
=====================================

STREAM_UNIT_DRIVER -- requirements
Module: stream_unit_driver

Interface
REQ-001 Parameters: none; widths fixed (address 8, data 32, count 9).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 io_start  in  1  one-cycle run request, sampled in IDLE only.
REQ-005 io_count  in  9  items per run, captured at start; 0 means an empty run; values above 256 are clamped to 256.
REQ-006 io_seed / io_key  in  32 each  pattern seeds, captured at start.
REQ-007 io_memWrite_valid, io_memWrite_payload_address[8], io_memWrite_payload_data[32]  out  flow, no ready.
REQ-008 io_cmdA_valid out, io_cmdA_ready in, io_cmdA_payload[8] out  read-address stream.
REQ-009 io_cmdB_valid out, io_cmdB_ready in, io_cmdB_payload[32] out  operand stream.
REQ-010 io_rsp_valid in, io_rsp_ready out, io_rsp_payload[32] in  result stream.
REQ-011 io_busy out 1; io_done out 1 (one-cycle pulse); io_errorCount out 9; io_firstErrorIndex out 8.

Function
REQ-012 Pattern for item i (0..N-1): D(i) = seed ^ {i,i,i,i}; K(i) = key + i (mod 2^32); E(i) = D(i) ^ K(i).
REQ-013 FSM states IDLE, WRITE, RUN, DONE; IDLE->WRITE on io_start when N>0; IDLE->DONE on io_start when N=0.
REQ-014 WRITE: one write per cycle, address i, data D(i), i = 0..N-1; memWrite_valid is high for exactly N consecutive cycles; WRITE->RUN after the last write.
REQ-015 RUN: cmdA_valid is high while issuedA<N, with payload issuedA; cmdB_valid is high while issuedB<N, with payload K(issuedB).
REQ-016 cmdA and cmdB advance independently: each counter increments only on its own valid&&ready.
REQ-017 Valid and payload on cmdA/cmdB hold stable until the transfer fires, and valid never drops before then.
REQ-018 rsp_ready is 1 throughout RUN and 0 in every other state; rsp_valid outside RUN is ignored.
REQ-019 Responses are in order: on each rsp fire, compare payload against E(received), then increment received.
REQ-020 On a mismatch, errorCount increments by 1; on the first mismatch of a run, firstErrorIndex latches the item index.
REQ-021 RUN->DONE in the cycle after the fire with received=N-1.
REQ-022 DONE lasts one cycle: io_done=1, then ->IDLE.
REQ-023 io_busy=1 in WRITE and RUN.
REQ-024 errorCount and firstErrorIndex hold until the next accepted start, which clears them.
REQ-025 io_start in any non-IDLE state is ignored.
REQ-026 All counters are 9 bit; address and index use bits [7:0]; N=256 writes addresses 0..255 with no wrap before completion.

Reset
REQ-027 Asynchronous assertion forces IDLE, with all counters and captured config cleared to 0 and all outputs 0, including valids, rsp_ready, busy, done and payloads.
REQ-028 Reset mid-run abandons the run; no done pulse is issued and no output glitches high during reset.

Structure
REQ-029 Shared package holds: ADDR_W=8, DATA_W=32, CNT_W=9, the FSM state enum, and pattern functions D, K, E.
REQ-030 One sub-module, stream_unit_driver_checker, holds the received counter, comparison, errorCount and firstErrorIndex; the top holds the FSM and issue counters.

Verification
REQ-031 Loopback to a correct XOR responder, N=4, seed=0x12345678, key=0x1: 4 writes (addr 0..3, data 0x12345678, 0x13355779, ...), then done pulse with errorCount=0.
REQ-032 Responder corrupts rsp #2 (bit0 flipped), N=8 -> errorCount=1, firstErrorIndex=2.
REQ-033 cmdA_ready held 0 for 10 cycles while cmdB_ready=1, N=3 -> all 3 cmdB sent, cmdA payload 0 held stable, and the run completes with 0 errors.
REQ-034 io_count=0 -> no writes, no commands, done one cycle after start; io_count=300 -> 256 writes, addresses ending at 255.
REQ-035 Reset asserted mid-RUN at received=5 -> outputs go 0 immediately, state returns to IDLE, no done pulse; a new start then runs clean.
REQ-036 Start pulsed during RUN -> ignored; counters unaffected.

Source files
------------

// File: rtl/stream_unit_driver_pkg.sv
// Shared widths, FSM state encoding and test-pattern functions for the stream unit driver.
package stream_unit_driver_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 9;

  // Largest run length; larger requests are clamped to this
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(256);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // Data written to memory for item idx
  function automatic logic [DATA_W-1:0] pat_d(input logic [DATA_W-1:0] seed,
                                              input logic [ADDR_W-1:0] idx);
    return seed ^ {4{idx}};
  endfunction

  // Operand sent on cmdB for item idx
  function automatic logic [DATA_W-1:0] pat_k(input logic [DATA_W-1:0] key,
                                              input logic [ADDR_W-1:0] idx);
    return key + DATA_W'(idx);
  endfunction

  // Response expected back for item idx
  function automatic logic [DATA_W-1:0] pat_e(input logic [DATA_W-1:0] seed,
                                              input logic [DATA_W-1:0] key,
                                              input logic [ADDR_W-1:0] idx);
    return pat_d(seed, idx) ^ pat_k(key, idx);
  endfunction

endpackage

// File: rtl/stream_unit_driver_checker.sv
// In-order response checker: counts received items, compares against the
// expected pattern and records error count and first failing index.
module stream_unit_driver_checker
  import stream_unit_driver_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_fire,
  input  logic [DATA_W-1:0] i_payload,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [DATA_W-1:0] i_key,
  input  logic [CNT_W-1:0]  i_n,
  output logic              o_last_fire_c,
  output logic [CNT_W-1:0]  o_error_count,
  output logic [ADDR_W-1:0] o_first_error_index
);

  logic [CNT_W-1:0]  r_received;
  logic [CNT_W-1:0]  r_error_count;
  logic [ADDR_W-1:0] r_first_error_index;
  logic              r_err_seen;
  logic [DATA_W-1:0] w_expected;
  logic              w_mismatch;

  assign w_expected    = pat_e(i_seed, i_key, r_received[ADDR_W-1:0]);
  assign w_mismatch    = (i_payload != w_expected);
  assign o_last_fire_c = i_fire && ((r_received + CNT_W'(1)) == i_n);

  // Receive counter and error bookkeeping; cleared by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_received          <= '0;
      r_error_count       <= '0;
      r_first_error_index <= '0;
      r_err_seen          <= 1'b0;
    end else if (i_clear) begin
      r_received          <= '0;
      r_error_count       <= '0;
      r_first_error_index <= '0;
      r_err_seen          <= 1'b0;
    end else if (i_fire) begin
      r_received <= r_received + CNT_W'(1);
      if (w_mismatch) begin
        r_error_count <= r_error_count + CNT_W'(1);
        if (!r_err_seen) begin
          r_first_error_index <= r_received[ADDR_W-1:0];
          r_err_seen          <= 1'b1;
        end
      end
    end
  end

  assign o_error_count       = r_error_count;
  assign o_first_error_index = r_first_error_index;

endmodule

// File: rtl/stream_unit_driver.sv
// Stream unit driver: writes a seeded pattern to memory, then streams read
// addresses and operands out and checks the returned results in order.
module stream_unit_driver
  import stream_unit_driver_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              io_start,
  input  logic [CNT_W-1:0]  io_count,
  input  logic [DATA_W-1:0] io_seed,
  input  logic [DATA_W-1:0] io_key,
  output logic              io_memWrite_valid,
  output logic [ADDR_W-1:0] io_memWrite_payload_address,
  output logic [DATA_W-1:0] io_memWrite_payload_data,
  output logic              io_cmdA_valid,
  input  logic              io_cmdA_ready,
  output logic [ADDR_W-1:0] io_cmdA_payload,
  output logic              io_cmdB_valid,
  input  logic              io_cmdB_ready,
  output logic [DATA_W-1:0] io_cmdB_payload,
  input  logic              io_rsp_valid,
  output logic              io_rsp_ready,
  input  logic [DATA_W-1:0] io_rsp_payload,
  output logic              io_busy,
  output logic              io_done,
  output logic [CNT_W-1:0]  io_errorCount,
  output logic [ADDR_W-1:0] io_firstErrorIndex
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_n;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_key;
  logic [CNT_W-1:0]  r_wr_idx;
  logic [CNT_W-1:0]  r_issued_a;
  logic [CNT_W-1:0]  r_issued_b;
  logic              r_mw_valid;
  mem_wr_t           r_mw;
  logic              r_a_valid;
  logic              r_b_valid;
  logic [DATA_W-1:0] r_b_payload;
  logic              r_rsp_ready;
  logic              r_busy;
  logic              r_done;

  logic [CNT_W-1:0]  w_n_clamped;
  logic [CNT_W-1:0]  w_wr_next;
  logic [CNT_W-1:0]  w_a_next;
  logic [CNT_W-1:0]  w_b_next;
  logic              w_start_acc;
  logic              w_rsp_fire;
  logic              w_last_fire_c;
  logic [CNT_W-1:0]  w_error_count;
  logic [ADDR_W-1:0] w_first_error_index;

  assign w_n_clamped = (io_count > MAX_N) ? MAX_N : io_count;
  assign w_wr_next   = r_wr_idx + CNT_W'(1);
  assign w_a_next    = r_issued_a + CNT_W'(1);
  assign w_b_next    = r_issued_b + CNT_W'(1);
  assign w_start_acc = io_start && (r_state == ST_IDLE);
  assign w_rsp_fire  = io_rsp_valid && r_rsp_ready;

  // Run controller: state, issue counters and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_seed      <= '0;
      r_key       <= '0;
      r_wr_idx    <= '0;
      r_issued_a  <= '0;
      r_issued_b  <= '0;
      r_mw_valid  <= 1'b0;
      r_mw        <= '0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
      r_b_payload <= '0;
      r_rsp_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            r_n        <= w_n_clamped;
            r_seed     <= io_seed;
            r_key      <= io_key;
            r_wr_idx   <= '0;
            r_issued_a <= '0;
            r_issued_b <= '0;
            if (w_n_clamped == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_WRITE;
              r_busy     <= 1'b1;
              r_mw_valid <= 1'b1;
              r_mw.addr  <= '0;
              r_mw.data  <= pat_d(io_seed, ADDR_W'(0));
            end
          end
        end
        ST_WRITE: begin
          // The write on display is the last one when wr_idx == N-1
          if (w_wr_next == r_n) begin
            r_mw_valid  <= 1'b0;
            r_state     <= ST_RUN;
            r_a_valid   <= 1'b1;
            r_b_valid   <= 1'b1;
            r_b_payload <= pat_k(r_key, ADDR_W'(0));
            r_rsp_ready <= 1'b1;
          end else begin
            r_wr_idx  <= w_wr_next;
            r_mw.addr <= w_wr_next[ADDR_W-1:0];
            r_mw.data <= pat_d(r_seed, w_wr_next[ADDR_W-1:0]);
          end
        end
        ST_RUN: begin
          if (r_a_valid && io_cmdA_ready) begin
            r_issued_a <= w_a_next;
            r_a_valid  <= (w_a_next < r_n);
          end
          if (r_b_valid && io_cmdB_ready) begin
            r_issued_b  <= w_b_next;
            r_b_valid   <= (w_b_next < r_n);
            r_b_payload <= pat_k(r_key, w_b_next[ADDR_W-1:0]);
          end
          if (w_last_fire_c) begin
            r_state     <= ST_DONE;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_a_valid   <= 1'b0;
            r_b_valid   <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  stream_unit_driver_checker u_checker (
    .clk                 (clk),
    .reset               (reset),
    .i_clear             (w_start_acc),
    .i_fire              (w_rsp_fire),
    .i_payload           (io_rsp_payload),
    .i_seed              (r_seed),
    .i_key               (r_key),
    .i_n                 (r_n),
    .o_last_fire_c       (w_last_fire_c),
    .o_error_count       (w_error_count),
    .o_first_error_index (w_first_error_index)
  );

  assign io_memWrite_valid           = r_mw_valid;
  assign io_memWrite_payload_address = r_mw.addr;
  assign io_memWrite_payload_data    = r_mw.data;
  assign io_cmdA_valid               = r_a_valid;
  assign io_cmdA_payload             = r_issued_a[ADDR_W-1:0];
  assign io_cmdB_valid               = r_b_valid;
  assign io_cmdB_payload             = r_b_payload;
  assign io_rsp_ready                = r_rsp_ready;
  assign io_busy                     = r_busy;
  assign io_done                     = r_done;
  assign io_errorCount               = w_error_count;
  assign io_firstErrorIndex          = w_first_error_index;

endmodule

// File: tb/tb_stream_unit_driver.sv
// Scoreboard bench for stream_unit_driver with a memory-backed XOR responder.
module tb_stream_unit_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_start;
  logic [8:0]  io_count;
  logic [31:0] io_seed;
  logic [31:0] io_key;
  logic        io_memWrite_valid;
  logic [7:0]  io_memWrite_payload_address;
  logic [31:0] io_memWrite_payload_data;
  logic        io_cmdA_valid;
  logic        io_cmdA_ready;
  logic [7:0]  io_cmdA_payload;
  logic        io_cmdB_valid;
  logic        io_cmdB_ready;
  logic [31:0] io_cmdB_payload;
  logic        io_rsp_valid;
  logic        io_rsp_ready;
  logic [31:0] io_rsp_payload;
  logic        io_busy;
  logic        io_done;
  logic [8:0]  io_errorCount;
  logic [7:0]  io_firstErrorIndex;

  stream_unit_driver dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_start                    (io_start),
    .io_count                    (io_count),
    .io_seed                     (io_seed),
    .io_key                      (io_key),
    .io_memWrite_valid           (io_memWrite_valid),
    .io_memWrite_payload_address (io_memWrite_payload_address),
    .io_memWrite_payload_data    (io_memWrite_payload_data),
    .io_cmdA_valid               (io_cmdA_valid),
    .io_cmdA_ready               (io_cmdA_ready),
    .io_cmdA_payload             (io_cmdA_payload),
    .io_cmdB_valid               (io_cmdB_valid),
    .io_cmdB_ready               (io_cmdB_ready),
    .io_cmdB_payload             (io_cmdB_payload),
    .io_rsp_valid                (io_rsp_valid),
    .io_rsp_ready                (io_rsp_ready),
    .io_rsp_payload              (io_rsp_payload),
    .io_busy                     (io_busy),
    .io_done                     (io_done),
    .io_errorCount               (io_errorCount),
    .io_firstErrorIndex          (io_firstErrorIndex)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected-response queues filled by stimulus, drained by the monitor
  logic [39:0] exp_wr_q[$];
  logic [7:0]  exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [16:0] exp_done_q[$];

  // Responder state
  logic [7:0]  pa_q[$];
  logic [31:0] pb_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] mem [256];
  logic [31:0] wdata_log [1024];
  logic [7:0]  waddr_log [1024];

  int wr_cnt = 0, a_fired = 0, b_fired = 0, done_cnt = 0, rsp_cnt = 0, rsp_gen = 0;
  int a_stall_cnt = 0;
  int a_stall_base = 0, a_hold = 0, corrupt_abs = -1;
  int wr_base = 0, a_base = 0, b_base = 0, done_base = 0, rsp_base = 0;
  bit chk_b_first = 1'b0;
  int cyc_p = 0, done_cyc = 0, start_cyc = 0;

  always @(posedge clk) cyc_p <= cyc_p + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  function automatic logic [31:0] m_d(input logic [31:0] s, input int i);
    logic [7:0] b;
    b = 8'(i);
    return s ^ {b, b, b, b};
  endfunction

  function automatic logic [31:0] m_k(input logic [31:0] k, input int i);
    return k + 32'(i);
  endfunction

  // Monitor and responder: inputs chosen here are used at the next rising edge
  always @(negedge clk) begin
    logic [39:0] ew;
    logic [16:0] ed;
    logic [31:0] r;
    logic        a_rdy;
    if (io_memWrite_valid) begin
      wdata_log[10'(wr_cnt)] = io_memWrite_payload_data;
      waddr_log[10'(wr_cnt)] = io_memWrite_payload_address;
      mem[io_memWrite_payload_address] = io_memWrite_payload_data;
      wr_cnt++;
      if (exp_wr_q.size() == 0)
        fail_now("unexpected_write", {24'd0, io_memWrite_payload_address, io_memWrite_payload_data});
      else begin
        ew = exp_wr_q.pop_front();
        check("mem_write", {24'd0, io_memWrite_payload_address, io_memWrite_payload_data}, {24'd0, ew});
      end
    end
    if (io_done) begin
      done_cnt++;
      done_cyc = cyc_p;
      if (exp_done_q.size() == 0)
        fail_now("unexpected_done", {47'd0, io_errorCount, io_firstErrorIndex});
      else begin
        ed = exp_done_q.pop_front();
        check("done_status", {47'd0, io_errorCount, io_firstErrorIndex}, {47'd0, ed});
      end
    end
    if (rsp_q.size() != 0) begin
      io_rsp_valid   = 1'b1;
      io_rsp_payload = rsp_q[0];
    end else begin
      io_rsp_valid   = 1'b0;
      io_rsp_payload = '0;
    end
    if (io_rsp_valid && io_rsp_ready) begin
      rsp_q.delete(0);
      rsp_cnt++;
    end
    io_cmdB_ready = 1'b1;
    if (io_cmdB_valid) begin
      if (exp_b_q.size() == 0) fail_now("unexpected_cmdB", {32'd0, io_cmdB_payload});
      else begin
        check("cmdB_payload", {32'd0, io_cmdB_payload}, {32'd0, exp_b_q[0]});
        exp_b_q.delete(0);
        pb_q.push_back(io_cmdB_payload);
        b_fired++;
      end
    end
    a_rdy = !(io_cmdA_valid && ((a_stall_cnt - a_stall_base) < a_hold));
    if (!a_rdy) a_stall_cnt++;
    io_cmdA_ready = a_rdy;
    if (io_cmdA_valid) begin
      if (exp_a_q.size() == 0) fail_now("unexpected_cmdA", {56'd0, io_cmdA_payload});
      else begin
        check("cmdA_payload", {56'd0, io_cmdA_payload}, {56'd0, exp_a_q[0]});
        if (a_rdy) begin
          if (chk_b_first && (a_fired == a_base)) check("cmdB_done_before_cmdA", 64'(b_fired - b_base), 64'd3);
          exp_a_q.delete(0);
          pa_q.push_back(io_cmdA_payload);
          a_fired++;
        end
      end
    end
    while (pa_q.size() != 0 && pb_q.size() != 0) begin
      r = mem[pa_q[0]] ^ pb_q[0];
      if (rsp_gen == corrupt_abs) r[0] = ~r[0];
      rsp_gen++;
      rsp_q.push_back(r);
      pa_q.delete(0);
      pb_q.delete(0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, {58'd0, io_memWrite_valid, io_cmdA_valid, io_cmdB_valid,
                            io_rsp_ready, io_busy, io_done}, 64'd0);
    check({tag, "_addr_idx"}, {31'd0, io_memWrite_payload_address, io_cmdA_payload,
                               io_errorCount, io_firstErrorIndex}, 64'd0);
    check({tag, "_wdata"}, {32'd0, io_memWrite_payload_data}, 64'd0);
    check({tag, "_cmdB"}, {32'd0, io_cmdB_payload}, 64'd0);
  endtask

  task automatic start_run(input int cnt, input logic [31:0] seed, input logic [31:0] key,
                           input int corrupt, input int hold_a,
                           input logic [8:0] exp_err, input logic [7:0] exp_first);
    int n;
    n = (cnt > 256) ? 256 : cnt;
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back({8'(i), m_d(seed, i)});
      exp_a_q.push_back(8'(i));
      exp_b_q.push_back(m_k(key, i));
    end
    exp_done_q.push_back({exp_err, exp_first});
    wr_base      = wr_cnt;
    a_base       = a_fired;
    b_base       = b_fired;
    done_base    = done_cnt;
    rsp_base     = rsp_cnt;
    a_stall_base = a_stall_cnt;
    a_hold       = hold_a;
    corrupt_abs  = (corrupt < 0) ? -1 : rsp_gen + corrupt;
    io_count     = 9'(cnt);
    io_seed      = seed;
    io_key       = key;
    io_start     = 1'b1;
    start_cyc    = cyc_p;
    step();
    io_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == done_base && k < 4000) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != done_base), 64'd1);
    step();
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    io_start = 1'b0;
    io_count = '0;
    io_seed  = '0;
    io_key   = '0;
    #1;
    check_idle_outputs("reset");
    repeat (3) step();
    reset = 1'b0;
    step();

    // Clean loopback, N=4
    start_run(4, 32'h12345678, 32'h1, -1, 0, 9'd0, 8'd0);
    wait_done("loop4");
    check("loop4_writes", 64'(wr_cnt - wr_base), 64'd4);
    check("loop4_data0", {32'd0, wdata_log[10'(wr_base)]}, 64'h12345678);
    check("loop4_data1", {32'd0, wdata_log[10'(wr_base + 1)]}, 64'h13355779);
    check("loop4_addr3", {56'd0, waddr_log[10'(wr_base + 3)]}, 64'd3);
    check("loop4_idle_busy", {63'd0, io_busy}, 64'd0);

    // Corrupted response #2, N=8, key wraps past 2^32
    start_run(8, 32'hCAFEF00D, 32'hFFFFFFFE, 2, 0, 9'd1, 8'd2);
    wait_done("corrupt8");
    repeat (4) step();
    check("corrupt8_err_hold", {55'd0, io_errorCount}, 64'd1);
    check("corrupt8_first_hold", {56'd0, io_firstErrorIndex}, 64'd2);

    // cmdA stalled 10 cycles while cmdB flows, N=3
    chk_b_first = 1'b1;
    start_run(3, 32'hA5A5A5A5, 32'h100, -1, 10, 9'd0, 8'd0);
    wait_done("stallA");
    chk_b_first = 1'b0;
    check("stallA_stalls", 64'(a_stall_cnt - a_stall_base), 64'd10);

    // Empty run
    start_run(0, 32'h11111111, 32'h2, -1, 0, 9'd0, 8'd0);
    wait_done("empty");
    check("empty_latency", 64'(done_cyc - start_cyc), 64'd1);
    check("empty_writes", 64'(wr_cnt - wr_base), 64'd0);
    check("empty_cmds", 64'((a_fired - a_base) + (b_fired - b_base)), 64'd0);

    // Clamped run, 300 requested
    start_run(300, 32'h0, 32'h0, -1, 0, 9'd0, 8'd0);
    wait_done("clamp");
    check("clamp_writes", 64'(wr_cnt - wr_base), 64'd256);
    check("clamp_last_addr", {56'd0, waddr_log[10'(wr_cnt - 1)]}, 64'd255);

    // Reset in RUN after 5 responses
    start_run(8, 32'h5555AAAA, 32'h7, -1, 0, 9'd0, 8'd0);
    k = 0;
    while ((rsp_cnt - rsp_base) < 5 && k < 2000) begin
      step();
      k++;
    end
    check("midrun_reached_rsp5", 64'((rsp_cnt - rsp_base) >= 5), 64'd1);
    step();
    reset = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    exp_wr_q.delete();
    exp_a_q.delete();
    exp_b_q.delete();
    exp_done_q.delete();
    pa_q.delete();
    pb_q.delete();
    rsp_q.delete();
    repeat (3) step();
    reset = 1'b0;
    step();
    check_idle_outputs("post_reset");
    repeat (5) step();
    start_run(5, 32'h0BADBEEF, 32'h3, -1, 0, 9'd0, 8'd0);
    wait_done("after_reset");

    // Start pulsed during RUN is ignored
    start_run(8, 32'h0F0F0F0F, 32'h80000000, -1, 0, 9'd0, 8'd0);
    k = 0;
    while (!io_rsp_ready && k < 200) begin
      step();
      k++;
    end
    check("ignore_in_run", {63'd0, io_rsp_ready}, 64'd1);
    io_count = 9'd5;
    io_seed  = 32'hDEADBEEF;
    io_start = 1'b1;
    step();
    io_start = 1'b0;
    wait_done("ignore");
    repeat (5) step();
    check("ignore_writes", 64'(wr_cnt - wr_base), 64'd8);
    check("ignore_done_count", 64'(done_cnt - done_base), 64'd1);
    check("ignore_cmdA_count", 64'(a_fired - a_base), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
